// File: rtl/bip_control_pkg.sv
// bip_isa_defs: shared ISA definitions for the 16-bit BIP core.
// Holds the opcode constants, the accumulator-mux (sel_a) encodings, the
// control FSM state encoding and the instruction field positions/widths.
package bip_isa_defs;

  // Instruction word layout: [15:11] opcode, [10:0] operand
  localparam int INSTR_W  = 16;
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 11;
  localparam int OPND_MSB = 10;
  localparam int OPND_LSB = 0;

  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_EXT = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: purely combinational opcode decoder for the BIP core.
// Ports:
//   opcode  in  5  instruction bits [15:11]
//   sel_a   out 2  accumulator input mux select
//   sel_b   out 1  ALU B mux select
//   op      out 1  ALU op (0 add, 1 sub)
//   wr_acc  out 1  accumulator write
//   wr_ram  out 1  data-RAM write
//   rd_ram  out 1  data-RAM read
//   is_halt out 1  opcode is HLT
// Opcodes 01000..11111 decode to NOP (all outputs low).
module bip_decoder
  import bip_isa_defs::*;
(
  input  logic [4:0] opcode,
  output logic [1:0] sel_a,
  output logic       sel_b,
  output logic       op,
  output logic       wr_acc,
  output logic       wr_ram,
  output logic       rd_ram,
  output logic       is_halt
);

  always_comb begin
    sel_a   = SELA_RAM;
    sel_b   = 1'b0;
    op      = 1'b0;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_HLT:  is_halt = 1'b1;
      OP_STO:  wr_ram  = 1'b1;
      OP_LD:   begin sel_a = SELA_RAM; rd_ram = 1'b1; wr_acc = 1'b1; end
      OP_LDI:  begin sel_a = SELA_EXT; wr_acc = 1'b1; end
      OP_ADD:  begin sel_a = SELA_ALU; rd_ram = 1'b1; wr_acc = 1'b1; end
      OP_ADDI: begin sel_a = SELA_ALU; sel_b = 1'b1; wr_acc = 1'b1; end
      OP_SUB:  begin sel_a = SELA_ALU; op = 1'b1; rd_ram = 1'b1; wr_acc = 1'b1; end
      OP_SUBI: begin sel_a = SELA_ALU; sel_b = 1'b1; op = 1'b1; wr_acc = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// bip_control: control unit of the 16-bit BIP core.
// Owns pc, instruction register and cycle counter; runs a 3-cycle
// FETCH/DECODE/EXEC sequence per instruction and drives single-cycle
// datapath strobes during EXEC.
// Ports:
//   clk, reset (sync, active-high), enable (low = stall)
//   instr_addr/instr_rd_en/instr_data : synchronous program memory
//   operand/data_addr                 : IR[10:0]
//   sel_a/sel_b/op/wr_acc/wr_ram/rd_ram : datapath controls (EXEC only)
//   halted, cycle_count               : status
module bip_control
  import bip_isa_defs::*;
#(
  parameter int PC_WIDTH      = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11,
  parameter int CYC_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic [PC_WIDTH-1:0]      instr_addr,
  output logic                     instr_rd_en,
  input  logic [INSTR_W-1:0]       instr_data,
  output logic [OPERAND_WIDTH-1:0] operand,
  output logic [OPERAND_WIDTH-1:0] data_addr,
  output logic [1:0]               sel_a,
  output logic                     sel_b,
  output logic                     op,
  output logic                     wr_acc,
  output logic                     wr_ram,
  output logic                     rd_ram,
  output logic                     halted,
  output logic [CYC_WIDTH-1:0]     cycle_count
);

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [INSTR_W-1:0]    r_ir;
  logic [CYC_WIDTH-1:0]  r_cyc;

  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic [1:0]              w_sel_a;
  logic                    w_sel_b, w_op, w_wr_acc, w_wr_ram, w_rd_ram, w_is_halt;
  logic                    w_exec_go;

  function automatic logic [CYC_WIDTH-1:0] sat_inc(input logic [CYC_WIDTH-1:0] v);
    return (&v) ? v : v + CYC_WIDTH'(1);
  endfunction

  assign w_opcode = r_ir[OPC_MSB:OPC_LSB];

  bip_decoder u_dec (
    .opcode  (w_opcode),
    .sel_a   (w_sel_a),
    .sel_b   (w_sel_b),
    .op      (w_op),
    .wr_acc  (w_wr_acc),
    .wr_ram  (w_wr_ram),
    .rd_ram  (w_rd_ram),
    .is_halt (w_is_halt)
  );

  // Strobes exist only in an EXEC cycle that will actually complete, so a
  // stalled EXEC never fires and its retry fires exactly once.
  assign w_exec_go   = (r_state == ST_EXEC) && enable && !reset;
  assign sel_a       = w_exec_go ? w_sel_a  : 2'b00;
  assign sel_b       = w_exec_go & w_sel_b;
  assign op          = w_exec_go & w_op;
  assign wr_acc      = w_exec_go & w_wr_acc;
  assign wr_ram      = w_exec_go & w_wr_ram;
  assign rd_ram      = w_exec_go & w_rd_ram;

  assign instr_addr  = r_pc;
  assign instr_rd_en = (r_state == ST_FETCH) && enable && !reset;
  assign operand     = r_ir[OPND_MSB:OPND_LSB];
  assign data_addr   = r_ir[OPND_MSB:OPND_LSB];
  assign halted      = (r_state == ST_HALT);
  assign cycle_count = r_cyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_cyc   <= '0;
    end else if (enable) begin
      if (r_state != ST_HALT) r_cyc <= sat_inc(r_cyc);
      case (r_state)
        ST_FETCH:  r_state <= ST_DECODE;
        ST_DECODE: begin
          r_ir    <= instr_data;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_is_halt) begin
            r_state <= ST_HALT;
          end else begin
            r_pc    <= r_pc + PC_WIDTH'(1);
            r_state <= ST_FETCH;
          end
        end
        default:   r_state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control.sv
module tb_bip_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] instr_addr;
  logic        instr_rd_en;
  logic [15:0] instr_data;
  logic [10:0] operand, data_addr;
  logic [1:0]  sel_a;
  logic        sel_b, op, wr_acc, wr_ram, rd_ram, halted;
  logic [31:0] cycle_count;

  bip_control dut (
    .clk(clk), .reset(reset), .enable(enable),
    .instr_addr(instr_addr), .instr_rd_en(instr_rd_en), .instr_data(instr_data),
    .operand(operand), .data_addr(data_addr),
    .sel_a(sel_a), .sel_b(sel_b), .op(op),
    .wr_acc(wr_acc), .wr_ram(wr_ram), .rd_ram(rd_ram),
    .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Synchronous program memory
  logic [15:0] mem [0:2047];
  always @(posedge clk) if (instr_rd_en) instr_data <= mem[instr_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected decode {sel_a[1:0], sel_b, op, wr_acc, wr_ram, rd_ram}
  function automatic logic [6:0] exp_dec(input logic [4:0] opc);
    case (opc)
      5'd1:    return 7'b00_0_0_0_1_0; // STO
      5'd2:    return 7'b00_0_0_1_0_1; // LD
      5'd3:    return 7'b01_0_0_1_0_0; // LDI
      5'd4:    return 7'b10_0_0_1_0_1; // ADD
      5'd5:    return 7'b10_1_0_1_0_0; // ADDI
      5'd6:    return 7'b10_0_1_1_0_1; // SUB
      5'd7:    return 7'b10_1_1_1_0_0; // SUBI
      default: return 7'b0;             // HLT, NOP
    endcase
  endfunction

  // Behavioural model: instruction step position 0..2, pc, IR, halt, count
  int          m_step = 0;
  logic        m_halt = 1'b0;
  logic [10:0] m_pc = '0;
  logic [15:0] m_ir = '0, m_fetch = '0;
  logic [31:0] m_cc = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_step = 0; m_halt = 1'b0; m_pc = '0; m_ir = '0; m_cc = '0; m_valid = 1'b1;
    end else if (enable && !m_halt) begin
      if (m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
      if (m_step == 0) begin
        m_fetch = mem[m_pc]; m_step = 1;
      end else if (m_step == 1) begin
        m_ir = m_fetch; m_step = 2;
      end else if (m_ir[15:11] == 5'd0) begin
        m_halt = 1'b1;
      end else begin
        m_pc = m_pc + 11'd1; m_step = 0;
      end
    end
  end

  logic       e_go, e_rd;
  logic [6:0] e_dec;
  always @(negedge clk) begin
    #2;
    if (m_valid) begin
      e_go  = (m_step == 2) && !m_halt && enable && !reset;
      e_rd  = (m_step == 0) && !m_halt && enable && !reset;
      e_dec = e_go ? exp_dec(m_ir[15:11]) : 7'b0;
      chk("ctrl", {instr_addr, instr_rd_en, operand, data_addr,
                   sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, halted},
                  {m_pc, e_rd, m_ir[10:0], m_ir[10:0], e_dec, m_halt});
      chk("cyc", cycle_count, m_cc);
    end
  end

  task automatic step(input logic en, input logic rst);
    @(negedge clk);
    enable = en;
    reset  = rst;
    #3;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1);
    chk("rst_nostrobe", {instr_rd_en, wr_acc, wr_ram, rd_ram}, 4'b0);
    step(1'b1, 1'b1);
  endtask

  task automatic clear_mem(input logic [15:0] fill);
    for (int i = 0; i < 2048; i++) mem[i] = fill;
  endtask

  initial begin
    clear_mem(16'h0000);
    // LDI 5
    mem[0] = 16'h1805;
    do_reset();
    step(1'b1, 1'b0);
    chk("t1_rd_en", instr_rd_en, 1'b1);
    chk("t1_addr0", instr_addr, 11'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("t1_ldi", {wr_acc, sel_a, operand}, {1'b1, 2'b01, 11'h005});
    step(1'b1, 1'b0);
    chk("t1_addr1", instr_addr, 11'd1);

    // STO 3, ADD 3, SUBI 7FF, HLT
    step(1'b1, 1'b1);
    clear_mem(16'h0000);
    mem[0] = 16'h0803; mem[1] = 16'h2003; mem[2] = 16'h3FFF; mem[3] = 16'h0000;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 1'b0);
      if (c == 2)  chk("t2_sto", {wr_ram, wr_acc, data_addr}, {1'b1, 1'b0, 11'd3});
      if (c == 5)  chk("t2_add", {sel_a, sel_b, op, rd_ram, wr_acc}, {2'b10, 1'b0, 1'b0, 1'b1, 1'b1});
      if (c == 8)  chk("t2_subi", {sel_b, op, rd_ram, operand}, {1'b1, 1'b1, 1'b0, 11'h7FF});
      if (c == 12) chk("t2_halted", halted, 1'b1);
    end
    chk("t2_pc", instr_addr, 11'd3);
    chk("t2_cc", cycle_count, 32'd12);
    chk("t2_halt_quiet", {instr_rd_en, wr_acc, wr_ram, rd_ram}, 4'b0);

    // Undefined opcode 11010 behaves as NOP
    clear_mem(16'h0000);
    mem[0] = 16'hD000;
    do_reset();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    chk("t3_nostrobe", {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, halted}, 8'b0);
    step(1'b1, 1'b0);
    chk("t3_pc", instr_addr, 11'd1);

    // ADDI 1 with enable low for 4 cycles during EXEC
    clear_mem(16'h0000);
    mem[0] = 16'h2801;
    do_reset();
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0);
      chk("t4_stall_wr", wr_acc, 1'b0);
    end
    step(1'b1, 1'b0);
    chk("t4_one_wr", {wr_acc, sel_a, sel_b}, {1'b1, 2'b10, 1'b1});
    step(1'b1, 1'b0);
    chk("t4_after", {wr_acc, instr_addr}, {1'b0, 11'd1});
    chk("t4_cc", cycle_count, 32'd3);

    // Reset in DECODE (pc=2), then reset in EXEC of an ADDI
    clear_mem(16'h2801);
    do_reset();
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0);
    chk("t6_pc2", instr_addr, 11'd2);
    step(1'b1, 1'b1);
    chk("t6_dec_rst", {instr_rd_en, wr_acc, wr_ram, rd_ram}, 4'b0);
    step(1'b1, 1'b0);
    chk("t6_post", {instr_addr, instr_rd_en, cycle_count}, {11'd0, 1'b1, 32'd0});
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("t6_exec_rst", {wr_acc, sel_a}, 3'b0);
    step(1'b1, 1'b0);
    chk("t6_post2", {instr_addr, cycle_count}, {11'd0, 32'd0});

    // pc wrap: random NOPs over the whole program space
    for (int i = 0; i < 2048; i++)
      mem[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
    do_reset();
    for (int k = 0; k < 7000; k++) begin
      step(1'b1, 1'b0);
      if (instr_addr == 11'h7FF) break;
    end
    chk("t5_reach", instr_addr, 11'h7FF);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    chk("t5_wrap", {instr_addr, instr_rd_en}, {11'd0, 1'b1});

    // Randomized run with stalls and occasional reset
    for (int i = 0; i < 2048; i++) begin
      int r;
      logic [4:0] opc;
      r = $urandom_range(0, 99);
      if (r < 3)       opc = 5'd0;
      else if (r < 60) opc = 5'($urandom_range(1, 7));
      else             opc = 5'($urandom_range(8, 31));
      mem[i] = {opc, 11'($urandom)};
    end
    do_reset();
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 2);

    step(1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit of the 16-bit BIP core; sits directly upstream of signal_extension.
- Owns the program counter and fetches 16-bit instructions from synchronous program memory.
- Splits each instruction into a 5-bit opcode and an 11-bit operand. The operand feeds signal_extension and the data-memory address; the opcode is decoded into single-cycle datapath strobes for accumulator, ALU and data RAM.

Parameters:
- PC_WIDTH, 11, program-counter and instruction-address width.
- OPCODE_WIDTH, 5, instruction bits [15:11].
- OPERAND_WIDTH, 11, instruction bits [10:0].
- CYC_WIDTH, 32, cycle-counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  step/run gate from the debug unit; low = stall.
- instr_addr  out  PC_WIDTH  program-memory address (= pc).
- instr_rd_en  out  1  program-memory read strobe.
- instr_data  in  16  program-memory data, valid 1 cycle after instr_rd_en.
- operand  out  OPERAND_WIDTH  IR[10:0], to signal_extension.operand.
- data_addr  out  OPERAND_WIDTH  IR[10:0], data-RAM address.
- sel_a  out  2  acc input mux: 00 data RAM, 01 extended operand, 10 ALU result.
- sel_b  out  1  ALU B mux: 0 data RAM, 1 extended operand.
- op  out  1  ALU op: 0 add, 1 sub.
- wr_acc  out  1  accumulator write strobe.
- wr_ram  out  1  data-RAM write strobe.
- rd_ram  out  1  data-RAM read strobe; data RAM reads combinationally.
- halted  out  1  high in HALT.
- cycle_count  out  CYC_WIDTH  executed-clock counter.

Behaviour:
- FSM states are FETCH, DECODE, EXEC and HALT. Every transition requires enable=1; with enable=0 the state, pc, IR and cycle_count all hold.
- FETCH: instr_rd_en=enable, instr_addr=pc; go to DECODE.
- DECODE: IR <= instr_data; go to EXEC.
- EXEC: strobes are combinational decode of IR[15:11], gated by (state==EXEC && enable && !reset).
  - Non-HLT: pc <= pc+1 and go to FETCH.
  - HLT: pc holds and the FSM goes to HALT.
- Fixed latency is 3 cycles per instruction with enable held high.
- HALT: halted=1, no strobes. Only reset leaves HALT.
- Decode table; unlisted outputs are 0:
  - 00000 HLT: none.
  - 00001 STO: wr_ram.
  - 00010 LD: sel_a=00, rd_ram, wr_acc.
  - 00011 LDI: sel_a=01, wr_acc.
  - 00100 ADD: sel_a=10, sel_b=0, op=0, rd_ram, wr_acc.
  - 00101 ADDI: sel_a=10, sel_b=1, op=0, wr_acc.
  - 00110 SUB: sel_a=10, sel_b=0, op=1, rd_ram, wr_acc.
  - 00111 SUBI: sel_a=10, sel_b=1, op=1, wr_acc.
  - 01000..11111: NOP, with no strobes; pc increments.
- operand and data_addr = IR[10:0] at all times.
- pc wraps from 2^PC_WIDTH-1 to 0 with no flag.
- cycle_count increments on each clock with enable=1 and state!=HALT, and saturates at all-ones.
- Reset, including mid-instruction, at the next edge: state=FETCH, pc=0, IR=0, cycle_count=0.
  - While reset is high, all strobes and instr_rd_en are 0.
  - halted=0 after reset.
- enable dropping during EXEC removes the strobes for that cycle. The instruction re-executes its EXEC cycle once enable returns, so there is no double write.

Decomposition:
- Shared include/package bip_isa_defs holds:
  - opcode constants HLT..SUBI;
  - sel_a encodings SELA_RAM/SELA_EXT/SELA_ALU;
  - FSM state encodings;
  - field widths and bit positions.
- One sub-module, bip_decoder: purely combinational, opcode -> {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, is_halt}.
- bip_control instantiates bip_decoder and holds the FSM, pc, IR and cycle counter.

Test Plan:
- Reset then enable=1, mem[0]=16'h1805 (LDI 5):
  - instr_rd_en=1 at cycle 0 with instr_addr=0.
  - At cycle 2: wr_acc=1, sel_a=01, operand=11'h005.
  - instr_addr=1 at cycle 3.
- Program STO 3, ADD 3, SUBI 11'h7FF, HLT:
  - STO: wr_ram=1 with data_addr=3.
  - ADD: sel_a=10, sel_b=0, op=0, rd_ram=1.
  - SUBI: sel_b=1, op=1, operand=11'h7FF.
  - HLT: halted=1; pc stays 3; cycle_count frozen at 12.
- Opcode 5'b11010:
  - No strobes in EXEC; pc increments by 1.
- enable low for 4 cycles during EXEC of ADDI 1:
  - No wr_acc while low; exactly one wr_acc pulse after enable returns.
  - cycle_count counts only enabled cycles.
- pc=11'h7FF executing NOP -> next instr_addr=0.
- reset asserted in DECODE:
  - At the next edge, state FETCH, pc=0, cycle_count=0.
  - No strobe is observed while reset is high.
